// File: rtl/led_display_uart_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : led_display_uart_frame_loader
// Description : Parses SYNC/CMD/ADDR/LEN/payload/CSUM packets from a UART
//               byte stream and writes 32-bit pixel words into the frame RAM
//               write port. Supports WRITE (N words) and FILL (one word
//               replicated over N addresses). Answers each packet with ACK
//               or NAK and flags checksum, protocol and overrun errors.
// Revision    : 1.0 - initial release
// ============================================================================
module led_display_uart_frame_loader #(
    parameter int         ADDR_W         = 11,
    parameter int         TIMEOUT_CYCLES = 200_000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_valid_in,
    output logic [7:0]        tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [31:0]       ram_wdata_out,
    output logic              ram_we_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              err_csum_out,
    output logic              err_proto_out,
    output logic              err_overrun_out
);

    localparam logic [7:0] c_CMD_WRITE = 8'h01;
    localparam logic [7:0] c_CMD_FILL  = 8'h02;
    localparam logic [7:0] c_ACK       = 8'h06;
    localparam logic [7:0] c_NAK       = 8'h15;
    localparam int         c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CMD     = 4'd1,
        S_ADDR_HI = 4'd2,
        S_ADDR_LO = 4'd3,
        S_LEN     = 4'd4,
        S_DATA    = 4'd5,
        S_CSUM    = 4'd6,
        S_FILL    = 4'd7,
        S_RESP    = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Packet context
    logic [7:0]          r_cmd;
    logic [7:0]          r_addr_hi;
    logic [ADDR_W-1:0]   r_start;
    logic [7:0]          r_len;
    logic [7:0]          r_csum;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_word_cnt;
    logic [23:0]         r_word_buf;
    logic [31:0]         r_fill_word;
    logic [7:0]          r_fill_cnt;
    logic [7:0]          r_resp;
    logic [c_TMO_W-1:0]  r_tmo;

    // Registered outputs
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_wdata;
    logic                r_ram_we;
    logic                r_frame_done;
    logic                r_err_csum;
    logic                r_err_proto;
    logic                r_err_overrun;

    // Decode helpers
    logic                w_in_pkt;
    logic                w_timeout;
    logic                w_cmd_ok;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_csum_ok;
    logic                w_fill_last;
    logic                w_overrun;
    logic                w_proto_err;

    // State register; reset abandons any packet in flight without a response
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, including timeout and unknown-command aborts
    always_comb begin
        w_next_state = r_state;
        w_proto_err  = 1'b0;
        w_in_pkt     = (r_state inside {S_CMD, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CSUM});
        w_cmd_ok     = (rx_data_in == c_CMD_WRITE) || (rx_data_in == c_CMD_FILL);
        w_word_done  = (r_byte_idx == 2'd3);
        w_last_word  = (r_cmd == c_CMD_FILL) || (r_word_cnt == r_len);
        w_csum_ok    = (rx_data_in == r_csum);
        w_fill_last  = (r_fill_cnt == r_len);
        w_overrun    = rx_valid_in && ((r_state == S_FILL) || (r_state == S_RESP));
        // An arriving byte always wins over an expiring timer in the same cycle
        w_timeout    = w_in_pkt && !rx_valid_in && (r_tmo == c_TMO_LAST);

        case (r_state)
            S_IDLE: begin
                if (rx_valid_in && (rx_data_in == SYNC_BYTE)) begin
                    w_next_state = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_valid_in) begin
                    if (w_cmd_ok) begin
                        w_next_state = S_ADDR_HI;
                    end else begin
                        w_next_state = S_IDLE;
                        w_proto_err  = 1'b1;
                    end
                end
            end
            S_ADDR_HI: begin
                if (rx_valid_in) w_next_state = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                if (rx_valid_in) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (rx_valid_in) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (rx_valid_in && w_word_done && w_last_word) begin
                    w_next_state = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_valid_in) begin
                    w_next_state = (w_csum_ok && (r_cmd == c_CMD_FILL)) ? S_FILL : S_RESP;
                end
            end
            S_FILL: begin
                if (w_fill_last) w_next_state = S_RESP;
            end
            S_RESP: begin
                if (tx_ready_in) w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_next_state = S_IDLE;
            w_proto_err  = 1'b1;
        end
    end

    // Inter-byte timer: restarts on every accepted byte, idles outside the packet
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_tmo <= '0;
        end else if (!w_in_pkt || rx_valid_in) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Header capture, running checksum and payload assembly
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_cmd       <= '0;
            r_addr_hi   <= '0;
            r_start     <= '0;
            r_len       <= '0;
            r_csum      <= '0;
            r_byte_idx  <= '0;
            r_word_cnt  <= '0;
            r_word_buf  <= '0;
            r_fill_word <= '0;
        end else if (rx_valid_in) begin
            case (r_state)
                S_IDLE: begin
                    r_csum <= '0;
                end
                S_CMD: begin
                    r_cmd  <= rx_data_in;
                    r_csum <= r_csum ^ rx_data_in;
                end
                S_ADDR_HI: begin
                    r_addr_hi <= rx_data_in;
                    r_csum    <= r_csum ^ rx_data_in;
                end
                S_ADDR_LO: begin
                    // Big-endian address; only the low ADDR_W bits select a RAM word
                    r_start <= ADDR_W'({r_addr_hi, rx_data_in});
                    r_csum  <= r_csum ^ rx_data_in;
                end
                S_LEN: begin
                    r_len      <= rx_data_in;
                    r_csum     <= r_csum ^ rx_data_in;
                    r_byte_idx <= '0;
                    r_word_cnt <= '0;
                end
                S_DATA: begin
                    r_csum     <= r_csum ^ rx_data_in;
                    r_byte_idx <= r_byte_idx + 1'b1;
                    if (w_word_done) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_cmd == c_CMD_FILL) begin
                            r_fill_word <= {r_word_buf, rx_data_in};
                        end
                    end else begin
                        r_word_buf <= {r_word_buf[15:0], rx_data_in};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM write port, fill sequencing, response byte and status pulses
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_ram_we      <= 1'b0;
            r_fill_cnt    <= '0;
            r_resp        <= '0;
            r_frame_done  <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_proto   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_ram_we      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_proto   <= w_proto_err;
            r_err_overrun <= w_overrun;

            case (r_state)
                S_DATA: begin
                    // WRITE words go out as soon as complete, before the checksum is known
                    if (rx_valid_in && w_word_done && (r_cmd == c_CMD_WRITE)) begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_start + ADDR_W'(r_word_cnt);
                        r_ram_wdata <= {r_word_buf, rx_data_in};
                    end
                end
                S_CSUM: begin
                    if (rx_valid_in) begin
                        if (!w_csum_ok) begin
                            r_err_csum <= 1'b1;
                            r_resp     <= c_NAK;
                        end else if (r_cmd == c_CMD_FILL) begin
                            r_fill_cnt <= '0;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_resp       <= c_ACK;
                        end
                    end
                end
                S_FILL: begin
                    r_ram_we    <= 1'b1;
                    r_ram_addr  <= r_start + ADDR_W'(r_fill_cnt);
                    r_ram_wdata <= r_fill_word;
                    r_fill_cnt  <= r_fill_cnt + 1'b1;
                    if (w_fill_last) begin
                        r_frame_done <= 1'b1;
                        r_resp       <= c_ACK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_valid_out    = (r_state == S_RESP);
    assign tx_data_out     = tx_valid_out ? r_resp : 8'h00;
    assign busy_out        = (r_state != S_IDLE);
    assign ram_addr_out    = r_ram_addr;
    assign ram_wdata_out   = r_ram_wdata;
    assign ram_we_out      = r_ram_we;
    assign frame_done_out  = r_frame_done;
    assign err_csum_out    = r_err_csum;
    assign err_proto_out   = r_err_proto;
    assign err_overrun_out = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_led_display_uart_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_display_uart_frame_loader
// Description : Self-checking bench for the UART frame loader. Packets are
//               built and their effects predicted by a byte-level protocol
//               model; observed RAM writes, responses and pulses are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_display_uart_frame_loader;

    localparam int ADDR_W = 11;
    localparam int TMO    = 300;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              tx_ready = 1'b1;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              busy;
    logic              frame_done;
    logic              err_csum;
    logic              err_proto;
    logic              err_overrun;

    led_display_uart_frame_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk_in          (clk),
        .n_reset_in      (n_reset),
        .rx_data_in      (rx_data),
        .rx_valid_in     (rx_valid),
        .tx_data_out     (tx_data),
        .tx_valid_out    (tx_valid),
        .tx_ready_in     (tx_ready),
        .ram_addr_out    (ram_addr),
        .ram_wdata_out   (ram_wdata),
        .ram_we_out      (ram_we),
        .busy_out        (busy),
        .frame_done_out  (frame_done),
        .err_csum_out    (err_csum),
        .err_proto_out   (err_proto),
        .err_overrun_out (err_overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observations
    logic [ADDR_W+31:0] obs_wr[$];
    int                 obs_cyc[$];
    logic [7:0]         obs_tx[$];
    int n_done, n_csum, n_proto, n_ovr;

    // Model outputs
    logic [31:0]        words[$];
    logic [7:0]         pkt_bytes[$];
    logic [ADDR_W+31:0] exp_wr[$];
    logic [7:0]         exp_tx;
    bit                 exp_good;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write, handshaken response byte and status pulse
    always @(negedge clk) begin
        if (n_reset) begin
            if (ram_we) begin
                obs_wr.push_back({ram_addr, ram_wdata});
                obs_cyc.push_back(cyc);
            end
            if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
            if (frame_done)  n_done++;
            if (err_csum)    n_csum++;
            if (err_proto)   n_proto++;
            if (err_overrun) n_ovr++;
        end
    end

    task automatic clear_obs();
        obs_wr.delete();
        obs_cyc.delete();
        obs_tx.delete();
        n_done = 0; n_csum = 0; n_proto = 0; n_ovr = 0;
    endtask

    // Protocol model: packet bytes, expected writes and expected response
    task automatic model_packet(input logic [7:0] cmd, input logic [15:0] addr,
                                input logic [7:0] len, input logic [7:0] mask);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w;
        int nw;
        pkt_bytes.delete();
        exp_wr.delete();
        pkt_bytes.push_back(8'hA5);
        pkt_bytes.push_back(cmd);
        pkt_bytes.push_back(addr[15:8]);
        pkt_bytes.push_back(addr[7:0]);
        pkt_bytes.push_back(len);
        cs = cmd ^ addr[15:8] ^ addr[7:0] ^ len;
        nw = (cmd == 8'h01) ? int'(len) + 1 : 1;
        for (int k = 0; k < nw; k++) begin
            w = words[k];
            for (int j = 3; j >= 0; j--) begin
                b = w[8*j +: 8];
                pkt_bytes.push_back(b);
                cs = cs ^ b;
            end
        end
        pkt_bytes.push_back(cs ^ mask);
        exp_good = (mask == 8'h00);
        exp_tx   = exp_good ? 8'h06 : 8'h15;
        if (cmd == 8'h01 || exp_good) begin
            for (int k = 0; k <= int'(len); k++) begin
                w = (cmd == 8'h01) ? words[k] : words[0];
                exp_wr.push_back({ADDR_W'((int'(addr) + k) % DEPTH), w});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic run_packet(output bit got);
        foreach (pkt_bytes[i]) send_byte(pkt_bytes[i], $urandom_range(0, 2));
        got = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (obs_tx.size() > 0) begin got = 1'b1; break; end
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            errors++; $display("FAIL reset_ram: we=%b addr=%h data=%h expected all 0", ram_we, ram_addr, ram_wdata); end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx: valid=%b data=%h expected 0", tx_valid, tx_data); end
        checks++; if ({frame_done, err_csum, err_proto, err_overrun} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000", {frame_done, err_csum, err_proto, err_overrun}); end
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        bit got;
        for (int c = 0; c < 2; c++) begin
            words.delete();
            words.push_back(32'h11223344);
            words.push_back(32'h55667788);
            model_packet(8'h01, 16'h0010, 8'd1, (c == 0) ? 8'h00 : 8'h01);
            clear_obs();
            run_packet(got);
            checks++; if (!got) begin errors++; $display("FAIL write%0d_resp: no response within bound", c); end
            checks++; if (obs_wr.size() !== exp_wr.size()) begin
                errors++; $display("FAIL write%0d_count: got %0d expected %0d", c, obs_wr.size(), exp_wr.size()); end
            else foreach (exp_wr[i]) begin
                checks++; if (obs_wr[i] !== exp_wr[i]) begin
                    errors++; $display("FAIL write%0d_word%0d: got %h expected %h", c, i, obs_wr[i], exp_wr[i]); end
            end
            checks++; if (got && obs_tx[0] !== exp_tx) begin
                errors++; $display("FAIL write%0d_tx: got %h expected %h", c, obs_tx[0], exp_tx); end
            checks++; if (n_done !== (c == 0 ? 1 : 0) || n_csum !== (c == 0 ? 0 : 1)) begin
                errors++; $display("FAIL write%0d_pulses: done=%0d csum=%0d expected %0d/%0d", c, n_done, n_csum, c == 0 ? 1 : 0, c); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write%0d_busy: got %b expected 0", c, busy); end
        end
    endtask

    task automatic test_fill_wrap();
        bit got;
        words.delete();
        words.push_back(32'h00000007);
        model_packet(8'h02, 16'h07FE, 8'd3, 8'h00);
        clear_obs();
        run_packet(got);
        checks++; if (!got || obs_tx[0] !== 8'h06) begin
            errors++; $display("FAIL fill_tx: got=%b byte %h expected 06", got, got ? obs_tx[0] : 8'h00); end
        checks++; if (obs_wr.size() !== exp_wr.size()) begin
            errors++; $display("FAIL fill_count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[i]) begin
            checks++; if (obs_wr[i] !== exp_wr[i] || obs_cyc[i] !== obs_cyc[0] + i) begin
                errors++; $display("FAIL fill_word%0d: got %h at cycle %0d expected %h at cycle %0d",
                                   i, obs_wr[i], obs_cyc[i], exp_wr[i], obs_cyc[0] + i); end
        end
        checks++; if (n_done !== 1 || n_csum !== 0) begin
            errors++; $display("FAIL fill_pulses: done=%0d csum=%0d expected 1/0", n_done, n_csum); end
    endtask

    task automatic test_random();
        bit got;
        logic [7:0] cmd, len, mask;
        int nw;
        for (int it = 0; it < 20; it++) begin
            cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            len  = (cmd == 8'h01) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 30));
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            nw   = (cmd == 8'h01) ? int'(len) + 1 : 1;
            words.delete();
            for (int k = 0; k < nw; k++)
                words.push_back(($urandom_range(0, 7) == 0) ? 32'hA5A5A5A5 : 32'($urandom));
            model_packet(cmd, 16'($urandom), len, mask);
            clear_obs();
            run_packet(got);
            checks++; if (!got || obs_tx[0] !== exp_tx) begin
                errors++; $display("FAIL rand%0d_tx: got=%b byte %h expected %h", it, got, got ? obs_tx[0] : 8'h00, exp_tx); end
            checks++; if (obs_wr.size() !== exp_wr.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_wr.size(), exp_wr.size()); end
            else foreach (exp_wr[i]) begin
                checks++; if (obs_wr[i] !== exp_wr[i]) begin
                    errors++; $display("FAIL rand%0d_word%0d: got %h expected %h", it, i, obs_wr[i], exp_wr[i]); end
            end
            checks++; if (n_done !== (exp_good ? 1 : 0) || n_csum !== (exp_good ? 0 : 1) || n_proto !== 0 || n_ovr !== 0) begin
                errors++; $display("FAIL rand%0d_pulses: done=%0d csum=%0d proto=%0d ovr=%0d good=%b",
                                   it, n_done, n_csum, n_proto, n_ovr, exp_good); end
        end
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] bad[4];
        bad[0] = 8'h00; bad[1] = 8'h03; bad[2] = 8'hA5; bad[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            clear_obs();
            send_byte(8'hA5, 0);
            send_byte(bad[i], 0);
            repeat (4) begin @(posedge clk); #1; end
            checks++; if (n_proto !== 1 || busy !== 1'b0 || obs_tx.size() !== 0) begin
                errors++; $display("FAIL unknown_cmd_%h: proto=%0d busy=%b tx=%0d expected 1/0/0", bad[i], n_proto, busy, obs_tx.size()); end
        end
    endtask

    task automatic test_timeout();
        bit got;
        int n;
        clear_obs();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        n = 0;
        while (n < TMO + 50) begin
            @(negedge clk);
            n++;
            if (err_proto) break;
        end
        checks++; if (n < TMO || n > TMO + 2) begin
            errors++; $display("FAIL timeout_latency: pulse after %0d cycles expected %0d..%0d", n, TMO, TMO + 2); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || obs_tx.size() !== 0) begin
            errors++; $display("FAIL timeout_idle: busy=%b tx=%0d expected 0/0", busy, obs_tx.size()); end
        words.delete();
        words.push_back(32'hCAFEF00D);
        model_packet(8'h01, 16'h0123, 8'd0, 8'h00);
        clear_obs();
        run_packet(got);
        checks++; if (!got || obs_tx[0] !== 8'h06 || obs_wr.size() !== 1) begin
            errors++; $display("FAIL timeout_recover: got=%b writes=%0d expected ACK and 1 write", got, obs_wr.size()); end
    endtask

    task automatic test_resp_overrun();
        bit all_high;
        int n;
        tx_ready = 1'b0;
        words.delete();
        words.push_back(32'h0BADBEEF);
        model_packet(8'h01, 16'h0200, 8'd0, 8'h00);
        clear_obs();
        foreach (pkt_bytes[i]) send_byte(pkt_bytes[i], 0);
        n = 0;
        while (n < 100 && !tx_valid) begin @(negedge clk); n++; end
        checks++; if (!tx_valid) begin errors++; $display("FAIL resp_enter: tx_valid got 0 expected 1"); end
        all_high = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            rx_valid = (i == 20);
            rx_data  = 8'hA5;
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h06) all_high = 1'b0;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        checks++; if (!all_high) begin errors++; $display("FAIL resp_hold: tx not held at 06 while not ready"); end
        checks++; if (n_ovr !== 1) begin errors++; $display("FAIL resp_overrun: got %0d pulses expected 1", n_ovr); end
        tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || tx_valid !== 1'b1) begin
            errors++; $display("FAIL resp_exit_early: busy=%b valid=%b expected 1/1", busy, tx_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL resp_exit: busy=%b valid=%b expected 0/0", busy, tx_valid); end
        checks++; if (obs_tx.size() !== 1) begin
            errors++; $display("FAIL resp_count: got %0d responses expected 1", obs_tx.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit got;
        int pre_writes;
        words.delete();
        words.push_back(32'h01020304);
        words.push_back(32'h05060708);
        model_packet(8'h01, 16'h0300, 8'd1, 8'h00);
        clear_obs();
        for (int i = 0; i < 11; i++) send_byte(pkt_bytes[i], 0);
        pre_writes = obs_wr.size();
        checks++; if (pre_writes !== 1) begin
            errors++; $display("FAIL midreset_word0: got %0d writes expected 1", pre_writes); end
        #2;
        n_reset = 1'b0;
        #1;
        checks++; if ({busy, ram_we, tx_valid, frame_done, err_csum, err_proto, err_overrun} !== 7'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 0000000",
                               {busy, ram_we, tx_valid, frame_done, err_csum, err_proto, err_overrun}); end
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (obs_wr.size() !== pre_writes || obs_tx.size() !== 0) begin
            errors++; $display("FAIL midreset_quiet: writes=%0d tx=%0d expected %0d/0", obs_wr.size(), obs_tx.size(), pre_writes); end
        clear_obs();
        send_byte(8'h00, 1);
        send_byte(8'h5A, 1);
        words.delete();
        words.push_back(32'($urandom));
        model_packet(8'h01, 16'h0456, 8'd0, 8'h00);
        run_packet(got);
        checks++; if (!got || obs_tx[0] !== 8'h06 || obs_wr.size() !== 1 || (obs_wr.size() == 1 && obs_wr[0] !== exp_wr[0])) begin
            errors++; $display("FAIL midreset_recover: got=%b writes=%0d expected ACK and write %h", got, obs_wr.size(), exp_wr[0]); end
    endtask

    initial begin
        clear_obs();
        #1;
        test_reset();
        test_write();
        test_fill_wrap();
        test_unknown_cmd();
        test_timeout();
        test_resp_overrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
